// File: rtl/spi_slave_regbank.sv
// SPI mode-0 slave exposing 2**AW 8-bit registers; all SPI pins are oversampled on clk_i.
// Writes commit on the 8th SCK rise of a data byte. Reads stream reg[addr] MSB-first on SCK falls.
module spi_slave_regbank #(
    parameter int AW = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    sck_i,
    input  logic                    mosi_i,
    input  logic                    ss_n_i,
    output logic                    miso_o,
    output logic                    miso_oe_o,
    output logic [8*(2**AW)-1:0]    regs_o,
    output logic                    wr_stb_o,
    output logic [AW-1:0]           wr_addr_o
);
    localparam int NREGS = 2**AW;

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    logic                  sck_m, sck_s, sck_d;
    logic                  mosi_m, mosi_s;
    logic                  ss_m, ss_s;
    logic                  rise, fall;
    state_t                state;
    logic [2:0]            bitcnt;
    logic [6:0]            sh;
    logic [7:0]            tx_sh;
    logic [7:0]            rx_byte;
    logic [AW-1:0]         addr;
    logic [AW-1:0]         cmd_addr;
    logic [NREGS-1:0][7:0] regs;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_m  <= 1'b0;
            sck_s  <= 1'b0;
            sck_d  <= 1'b0;
            mosi_m <= 1'b0;
            mosi_s <= 1'b0;
            ss_m   <= 1'b1;
            ss_s   <= 1'b1;
        end else begin
            sck_m  <= sck_i;
            sck_s  <= sck_m;
            sck_d  <= sck_s;
            mosi_m <= mosi_i;
            mosi_s <= mosi_m;
            ss_m   <= ss_n_i;
            ss_s   <= ss_m;
        end
    end

    assign rise      = sck_s & ~sck_d;
    assign fall      = ~sck_s & sck_d;
    assign rx_byte   = {sh, mosi_s};
    assign cmd_addr  = rx_byte[AW-1:0];
    assign miso_oe_o = ~ss_s;
    assign regs_o    = regs;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            bitcnt    <= 3'd0;
            sh        <= '0;
            tx_sh     <= 8'd0;
            addr      <= '0;
            regs      <= '0;
            miso_o    <= 1'b0;
            wr_stb_o  <= 1'b0;
            wr_addr_o <= '0;
        end else begin
            wr_stb_o <= 1'b0;
            // Deselect wins over a coincident 8th rise, so a cut-short byte never commits.
            if (ss_s) begin
                state  <= IDLE;
                bitcnt <= 3'd0;
                miso_o <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state  <= CMD;
                        bitcnt <= 3'd0;
                        sh     <= '0;
                        tx_sh  <= 8'd0;
                        miso_o <= 1'b0;
                    end
                    CMD: begin
                        if (rise) begin
                            sh     <= rx_byte[6:0];
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) begin
                                if (rx_byte[7]) begin
                                    state <= RDATA;
                                    tx_sh <= regs[cmd_addr];
                                    addr  <= cmd_addr + AW'(1);
                                end else begin
                                    state <= WDATA;
                                    addr  <= cmd_addr;
                                end
                            end
                        end
                    end
                    WDATA: begin
                        if (rise) begin
                            sh     <= rx_byte[6:0];
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) begin
                                regs[addr] <= rx_byte;
                                wr_stb_o   <= 1'b1;
                                wr_addr_o  <= addr;
                                addr       <= addr + AW'(1);
                            end
                        end
                    end
                    RDATA: begin
                        if (fall) begin
                            miso_o <= tx_sh[7];
                            tx_sh  <= {tx_sh[6:0], 1'b0};
                        end
                        if (rise) begin
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) begin
                                tx_sh <= regs[addr];
                                addr  <= addr + AW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_regbank.sv
// Bench for spi_slave_regbank: acts as a mode-0 master at the minimum SCK phase of 6 clk_i.
module tb_spi_slave_regbank;
    localparam int AW = 2;
    localparam int HP = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sck = 1'b0;
    logic          mosi = 1'b0;
    logic          ss_n = 1'b1;
    logic          miso, miso_oe, wr_stb;
    logic [31:0]   regs;
    logic [AW-1:0] wr_addr;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;
    wr_t wr_q[$];

    typedef struct {
        logic [7:0]       cmd;
        int               n;
        logic [3:0][7:0]  d;
        logic [4:0][7:0]  rx;
        bit               chk_rx;
        logic [31:0]      regs;
    } vec_t;
    vec_t v[6];

    spi_slave_regbank #(.AW(AW)) dut (
        .clk_i(clk), .rst_i(rst), .sck_i(sck), .mosi_i(mosi), .ss_n_i(ss_n),
        .miso_o(miso), .miso_oe_o(miso_oe), .regs_o(regs),
        .wr_stb_o(wr_stb), .wr_addr_o(wr_addr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive nbits MSB-first; miso is sampled just before each rising SCK.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            tick(HP);
            rx[i] = miso;
            sck = 1'b1;
            tick(HP);
            sck = 1'b0;
        end
    endtask

    task automatic do_frame(input logic [7:0] cmd, input int n, input logic [3:0][7:0] d,
                            output logic [4:0][7:0] rx);
        logic [7:0] b;
        rx = '0;
        ss_n = 1'b0;
        tick(HP);
        check("miso_oe_in_frame", miso_oe, 1'b1);
        spi_bits(cmd, 8, b);
        rx[0] = b;
        for (int i = 0; i < n; i++) begin
            spi_bits(d[i], 8, b);
            rx[i+1] = b;
        end
        tick(HP);
        ss_n = 1'b1;
        tick(2*HP);
        check("miso_oe_idle", miso_oe, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst && wr_stb) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual addr=%0d required none", wr_addr);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", regs[8*int'(e.addr) +: 8], e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0][7:0] rx;
        logic [7:0]      b;

        v[0] = '{cmd: 8'h02, n: 1, d: 32'h000000A5, rx: 40'h0, chk_rx: 1'b0, regs: 32'h00A50000};
        v[1] = '{cmd: 8'h03, n: 3, d: 32'h00332211, rx: 40'h0, chk_rx: 1'b0, regs: 32'h11A53322};
        v[2] = '{cmd: 8'h01, n: 2, d: 32'h0000C35A, rx: 40'h0, chk_rx: 1'b0, regs: 32'h11C35A22};
        v[3] = '{cmd: 8'h81, n: 2, d: 32'hFFFFFFFF, rx: 40'h0000C35A00, chk_rx: 1'b1, regs: 32'h11C35A22};
        v[4] = '{cmd: 8'h83, n: 3, d: 32'hFFFFFFFF, rx: 40'h005A221100, chk_rx: 1'b1, regs: 32'h11C35A22};
        v[5] = '{cmd: 8'h7C, n: 1, d: 32'h00000099, rx: 40'h0, chk_rx: 1'b0, regs: 32'h11C35A99};

        tick(3);
        check("rst_regs", regs, 32'h0);
        check("rst_miso", miso, 1'b0);
        check("rst_oe", miso_oe, 1'b0);
        check("rst_stb", wr_stb, 1'b0);
        check("rst_waddr", wr_addr, 2'd0);
        rst = 1'b0;
        tick(4);
        check("post_rst_regs", regs, 32'h0);

        for (int k = 0; k < 6; k++) begin
            if (!v[k].cmd[7])
                for (int i = 0; i < v[k].n; i++)
                    wr_q.push_back('{addr: v[k].cmd[AW-1:0] + AW'(i), data: v[k].d[i]});
            do_frame(v[k].cmd, v[k].n, v[k].d, rx);
            check($sformatf("vec%0d_regs", k), regs, v[k].regs);
            if (v[k].chk_rx)
                for (int i = 0; i <= v[k].n; i++)
                    check($sformatf("vec%0d_rx%0d", k, i), rx[i], v[k].rx[i]);
        end

        // Abort after 5 data bits: nothing commits.
        ss_n = 1'b0;
        tick(HP);
        spi_bits(8'h00, 8, b);
        spi_bits(8'hFF, 5, b);
        tick(HP);
        ss_n = 1'b1;
        tick(2*HP);
        check("abort5_regs", regs, 32'h11C35A99);

        wr_q.push_back('{addr: 2'd0, data: 8'h7E});
        do_frame(8'h00, 1, 32'h0000007E, rx);
        check("after_abort_regs", regs, 32'h11C35A7E);

        // ss_n released on the same clock as the 8th SCK rise.
        ss_n = 1'b0;
        tick(HP);
        spi_bits(8'h00, 8, b);
        spi_bits(8'h01, 7, b);
        mosi = 1'b1;
        tick(HP);
        sck = 1'b1;
        ss_n = 1'b1;
        tick(HP);
        sck = 1'b0;
        tick(2*HP);
        check("abort8_regs", regs, 32'h11C35A7E);

        // Reset in the middle of a read frame.
        ss_n = 1'b0;
        tick(HP);
        spi_bits(8'h83, 8, b);
        spi_bits(8'hFF, 3, b);
        rst = 1'b1;
        #1;
        check("midrst_regs", regs, 32'h0);
        check("midrst_miso", miso, 1'b0);
        check("midrst_oe", miso_oe, 1'b0);
        check("midrst_stb", wr_stb, 1'b0);
        ss_n = 1'b1;
        sck = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(4);

        wr_q.push_back('{addr: 2'd1, data: 8'hC3});
        do_frame(8'h01, 1, 32'h000000C3, rx);
        check("recover_regs", regs, 32'h0000C300);

        check("wr_q_drained", wr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
